// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: clocked stimulus/response sweep of a 3-input gate block against an expected truth table
module gate_vector_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [47:0] EXP_TABLE     = 48'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] stim_abc,
  input  logic [5:0] resp_pqrstu,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] fail_vec,
  output logic [5:0] fail_mask
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  // a zero settle time is treated as one cycle
  localparam logic [7:0] LOAD = (SETTLE_CYCLES == 0) ? 8'd1 : 8'(SETTLE_CYCLES);
  state_t r_state, w_state;
  logic [2:0] r_idx, w_idx, r_fvec, w_fvec;
  logic [7:0] r_cnt, w_cnt;
  logic [3:0] r_err, w_err;
  logic [5:0] r_fmask, w_fmask, w_exp;
  logic r_busy, w_busy, r_done, w_done, r_pass, w_pass, r_fv, w_fv, w_mis;
  assign w_exp = EXP_TABLE[6*r_idx +: 6];
  assign w_mis = resp_pqrstu != w_exp;
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_busy  = r_busy;
    w_done  = r_done;
    w_pass  = r_pass;
    w_err   = r_err;
    w_fv    = r_fv;
    w_fvec  = r_fvec;
    w_fmask = r_fmask;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_state = SETTLE;
        w_idx   = 3'd0;
        w_cnt   = LOAD;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        w_pass  = 1'b0;
        w_err   = 4'd0;
        w_fv    = 1'b0;
        w_fvec  = 3'd0;
        w_fmask = 6'd0;
      end
      SETTLE: begin
        w_cnt   = r_cnt - 8'd1;
        w_state = (r_cnt == 8'd1) ? CHECK : SETTLE;
      end
      CHECK: begin
        if (w_mis) begin
          w_err = r_err + 4'd1;
          if (!r_fv) begin
            w_fv    = 1'b1;
            w_fvec  = r_idx;
            w_fmask = resp_pqrstu ^ w_exp;
          end
        end
        if (r_idx != 3'd7) begin
          w_idx   = r_idx + 3'd1;
          w_cnt   = LOAD;
          w_state = SETTLE;
        end else begin
          w_state = DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = w_err == 4'd0;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_fv    <= 1'b0;
      r_fvec  <= 3'd0;
      r_fmask <= 6'd0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_err   <= w_err;
      r_fv    <= w_fv;
      r_fvec  <= w_fvec;
      r_fmask <= w_fmask;
    end
  assign stim_abc   = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fv;
  assign fail_vec   = r_fvec;
  assign fail_mask  = r_fmask;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer: three sequencers (settle 4, 1, 0) against a sweep-level model of the expected outputs
module tb_gate_vector_sequencer;
  localparam int PER [3] = '{5, 2, 2};
  logic clk = 0, rst_n = 0;
  logic start [3] = '{0, 0, 0};
  logic [2:0] stim [3], fvec [3];
  logic [5:0] resp [3], fmask [3];
  logic [3:0] errc [3];
  logic busy [3], done [3], pass [3], fv [3];
  int mode = 0, n_vec = 0, n_mis = 0;
  int mn [3] = '{0, 0, 0}, mmode [3] = '{0, 0, 0};
  bit mact [3] = '{0, 0, 0};
  always #5 clk = ~clk;
  function automatic logic [5:0] good(logic [2:0] v);
    logic a, b, c;
    {a, b, c} = v;
    return {a & b, a | b, ~(a & b & c), ~(a | c), a ^ b ^ c, ~(b ^ c)};
  endfunction
  function automatic logic [5:0] bad(logic [2:0] v, int md);
    return good(v) ^ ((md == 1 && v == 3'd5) ? 6'b000001 : 6'b0) ^ (md == 2 ? 6'h3f : 6'h0);
  endfunction
  function automatic logic [47:0] table_of();
    logic [47:0] t = '0;
    for (int v = 0; v < 8; v++) t[6*v +: 6] = good(3'(v));
    return t;
  endfunction
  localparam logic [47:0] EXP = table_of();
  assign resp[0] = bad(stim[0], mode);
  assign resp[1] = good(stim[1]);
  assign resp[2] = good(stim[2]);
  gate_vector_sequencer #(.SETTLE_CYCLES(4), .EXP_TABLE(EXP)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stim_abc(stim[0]), .resp_pqrstu(resp[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .fail_valid(fv[0]), .fail_vec(fvec[0]), .fail_mask(fmask[0]));
  gate_vector_sequencer #(.SETTLE_CYCLES(1), .EXP_TABLE(EXP)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stim_abc(stim[1]), .resp_pqrstu(resp[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .fail_valid(fv[1]), .fail_vec(fvec[1]), .fail_mask(fmask[1]));
  gate_vector_sequencer #(.SETTLE_CYCLES(0), .EXP_TABLE(EXP)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .stim_abc(stim[2]), .resp_pqrstu(resp[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
    .fail_valid(fv[2]), .fail_vec(fvec[2]), .fail_mask(fmask[2]));
  // model: edges elapsed since the sweep's start edge; sweeps take 8 vectors of PER edges each
  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 3; k++)
      if (!rst_n) mact[k] <= 0;
      else if ((!mact[k] || mn[k] == 8 * PER[k]) && start[k]) begin
        mact[k]  <= 1;
        mn[k]    <= 0;
        mmode[k] <= (k == 0) ? mode : 0;
      end else if (mact[k] && mn[k] < 8 * PER[k]) mn[k] <= mn[k] + 1;
  function automatic logic [19:0] exp_out(int k);
    int p = PER[k], m = mn[k], e = 0;
    logic fvl = 0, run;
    logic [2:0] fvc = 0;
    logic [5:0] fm = 0;
    if (!mact[k]) return 20'h0;
    for (int v = 0; v < m / p; v++)
      if (bad(3'(v), mmode[k]) != good(3'(v))) begin
        e++;
        if (!fvl) begin
          fvl = 1;
          fvc = 3'(v);
          fm  = bad(3'(v), mmode[k]) ^ good(3'(v));
        end
      end
    run = m < 8 * p;
    return {run ? 3'(m / p) : 3'd7, run, !run, !run && e == 0, 4'(e), fvl, fvc, fm};
  endfunction
  function automatic logic [19:0] got(int k);
    return {stim[k], busy[k], done[k], pass[k], errc[k], fv[k], fvec[k], fmask[k]};
  endfunction
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got(k) !== exp_out(k)) begin
        n_mis++;
        $display("FAIL cycle_compare dut%0d at %0t: got %h, want %h", k, $time, got(k), exp_out(k));
      end
    end
  task automatic check(string name, logic [31:0] g, logic [31:0] w);
    n_vec++;
    if (g !== w) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", name, g, w);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic sweep0(int md);
    mode = md;
    start[0] = 1;
    tick(1);
    start[0] = 0;
    tick(40);
  endtask
  initial begin
    #1 check("reset_state", got(0), 0);
    check("model_good_101", good(3'd5), 6'b011000);
    #11 rst_n = 1;
    tick(1);
    mode = 0;
    start[0] = 1;
    tick(1);
    start[0] = 0;
    tick(4);
    check("t1_stim_edge4", stim[0], 0);
    tick(1);
    check("t1_stim_edge5", stim[0], 1);
    tick(34);
    check("t1_done_edge39", done[0], 0);
    tick(1);
    check("t1_done_edge40", done[0], 1);
    check("t1_pass", pass[0], 1);
    check("t1_err", errc[0], 0);
    check("t1_fv", fv[0], 0);
    check("t1_stim", stim[0], 7);
    sweep0(1);
    check("t2_err", errc[0], 1);
    check("t2_fvec", fvec[0], 5);
    check("t2_fmask", fmask[0], 6'b000001);
    check("t2_fv", fv[0], 1);
    check("t2_pass", pass[0], 0);
    sweep0(2);
    check("t3_err", errc[0], 8);
    check("t3_fvec", fvec[0], 0);
    check("t3_fmask", fmask[0], 6'h3f);
    mode = 0;
    start[0] = 1;
    tick(21);
    start[0] = 0;
    tick(19);
    check("t4_done_edge39", done[0], 0);
    tick(1);
    check("t4_done_edge40", done[0], 1);
    check("t4_pass", pass[0], 1);
    start[0] = 1;
    tick(1);
    start[0] = 0;
    check("t4_restart_done", done[0], 0);
    check("t4_restart_pass", pass[0], 0);
    check("t4_restart_stim", stim[0], 0);
    check("t4_restart_busy", busy[0], 1);
    tick(17);
    check("t5_busy_pre", busy[0], 1);
    #2 rst_n = 0;
    #1 check("t5_async_reset", got(0), 0);
    #3 rst_n = 1;
    tick(5);
    check("t5_stays_idle", got(0), 0);
    start[1] = 1;
    start[2] = 1;
    tick(1);
    start[1] = 0;
    start[2] = 0;
    tick(15);
    check("t6_s1_done_edge15", done[1], 0);
    check("t6_s0_done_edge15", done[2], 0);
    tick(1);
    check("t6_s1_done_edge16", done[1], 1);
    check("t6_s0_done_edge16", done[2], 1);
    check("t6_s1_pass", pass[1], 1);
    check("t6_s0_pass", pass[2], 1);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
